// File: rtl/vocab_matcher_pkg.sv
// Shared types and constants for the vocabulary matcher.
package vocab_matcher_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CMP,
    S_SKIP_FETCH,
    S_SKIP_CHK,
    S_DONE
  } state_t;

  // Character value that terminates a word, and the vocabulary when seen at a word start.
  localparam int unsigned NUL = 0;

endpackage

// File: rtl/match_ptr_cnt.sv
// Saturating pointer/index counter with clear, load, increment and an at-max flag.
module match_ptr_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             at_max_c
);

  logic [WIDTH-1:0] q_nxt;

  assign at_max_c = (q == {WIDTH{1'b1}});

  // Clear wins over load, load over increment; increment never rolls over.
  always_comb begin
    q_nxt = q;
    if (clr) begin
      q_nxt = '0;
    end else if (load) begin
      q_nxt = load_val;
    end else if (inc && !at_max_c) begin
      q_nxt = q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/vocab_matcher.sv
// Searches a zero-terminated word list held in external SRAM for an exact match
// to a zero-terminated input word, reporting index and start address of the hit.
module vocab_matcher
  import vocab_matcher_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned VOCAB_ADDR_WIDTH = 8,
  parameter int unsigned WORD_ADDR_WIDTH  = 4,
  parameter int unsigned ID_WIDTH         = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        found,
  output logic [ID_WIDTH-1:0]         match_id,
  output logic [VOCAB_ADDR_WIDTH-1:0] match_addr,
  output logic                        vocab_rd,
  output logic [VOCAB_ADDR_WIDTH-1:0] vocab_addr,
  input  logic [DATA_WIDTH-1:0]       vocab_data,
  output logic                        word_rd,
  output logic [WORD_ADDR_WIDTH-1:0]  word_addr,
  input  logic [DATA_WIDTH-1:0]       word_data
);

  localparam logic [DATA_WIDTH-1:0] NUL_CHAR = DATA_WIDTH'(NUL);

  state_t state, state_nxt;

  logic                        vptr_clr, vptr_inc, vptr_max;
  logic                        wptr_clr, wptr_inc, wptr_max;
  logic                        widx_clr, widx_inc, widx_max;
  logic [VOCAB_ADDR_WIDTH-1:0] vptr;
  logic [WORD_ADDR_WIDTH-1:0]  wptr;
  logic [ID_WIDTH-1:0]         widx;

  logic [VOCAB_ADDR_WIDTH-1:0] wstart, wstart_nxt;
  logic                        found_nxt;
  logic [ID_WIDTH-1:0]         match_id_nxt;
  logic [VOCAB_ADDR_WIDTH-1:0] match_addr_nxt;
  logic                        busy_nxt, done_nxt, vocab_rd_nxt, word_rd_nxt;

  logic v_nul, w_nul, chars_eq, wptr_zero, advance;

  assign v_nul     = (vocab_data == NUL_CHAR);
  assign w_nul     = (word_data == NUL_CHAR);
  assign chars_eq  = (vocab_data == word_data);
  assign wptr_zero = (wptr == '0);

  match_ptr_cnt #(.WIDTH(VOCAB_ADDR_WIDTH)) u_vptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (vptr_clr),
    .load     (1'b0),
    .inc      (vptr_inc),
    .load_val ('0),
    .q        (vptr),
    .at_max_c (vptr_max)
  );

  match_ptr_cnt #(.WIDTH(WORD_ADDR_WIDTH)) u_wptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (wptr_clr),
    .load     (1'b0),
    .inc      (wptr_inc),
    .load_val ('0),
    .q        (wptr),
    .at_max_c (wptr_max)
  );

  match_ptr_cnt #(.WIDTH(ID_WIDTH)) u_widx (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (widx_clr),
    .load     (1'b0),
    .inc      (widx_inc),
    .load_val ('0),
    .q        (widx),
    .at_max_c (widx_max)
  );

  // Pointers are registers that only move on FSM command, so they double as read addresses.
  assign vocab_addr = vptr;
  assign word_addr  = wptr;

  always_comb begin
    state_nxt      = state;
    vptr_clr       = 1'b0;
    vptr_inc       = 1'b0;
    wptr_clr       = 1'b0;
    wptr_inc       = 1'b0;
    widx_clr       = 1'b0;
    widx_inc       = 1'b0;
    advance        = 1'b0;
    wstart_nxt     = wstart;
    found_nxt      = found;
    match_id_nxt   = match_id;
    match_addr_nxt = match_addr;

    case (state)
      S_IDLE: begin
        if (start) begin
          found_nxt      = 1'b0;
          match_id_nxt   = '0;
          match_addr_nxt = '0;
          vptr_clr       = 1'b1;
          wptr_clr       = 1'b1;
          widx_clr       = 1'b1;
          wstart_nxt     = '0;
          state_nxt      = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_CMP;
      S_CMP: begin
        if (wptr_zero && w_nul) begin
          state_nxt = S_DONE;
        end else if (wptr_zero && v_nul) begin
          state_nxt = S_DONE;
        end else if (chars_eq && v_nul) begin
          found_nxt      = 1'b1;
          match_id_nxt   = widx;
          match_addr_nxt = wstart;
          state_nxt      = S_DONE;
        end else if (chars_eq && !wptr_max) begin
          if (vptr_max) begin
            state_nxt = S_DONE;
          end else begin
            vptr_inc  = 1'b1;
            wptr_inc  = 1'b1;
            state_nxt = S_FETCH;
          end
        end else if (v_nul) begin
          advance = 1'b1;
        end else if (vptr_max) begin
          state_nxt = S_DONE;
        end else begin
          vptr_inc  = 1'b1;
          state_nxt = S_SKIP_FETCH;
        end
      end
      S_SKIP_FETCH: state_nxt = S_SKIP_CHK;
      S_SKIP_CHK: begin
        if (v_nul) begin
          advance = 1'b1;
        end else if (vptr_max) begin
          state_nxt = S_DONE;
        end else begin
          vptr_inc  = 1'b1;
          state_nxt = S_SKIP_FETCH;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Move to the next vocabulary word, unless memory or the index space is exhausted.
    if (advance) begin
      if (vptr_max || widx_max) begin
        state_nxt = S_DONE;
      end else begin
        vptr_inc   = 1'b1;
        wptr_clr   = 1'b1;
        widx_inc   = 1'b1;
        wstart_nxt = vptr + VOCAB_ADDR_WIDTH'(1);
        state_nxt  = S_FETCH;
      end
    end
  end

  assign busy_nxt     = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
  assign done_nxt     = (state_nxt == S_DONE);
  assign vocab_rd_nxt = (state_nxt == S_FETCH) || (state_nxt == S_SKIP_FETCH);
  assign word_rd_nxt  = (state_nxt == S_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wstart     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      match_id   <= '0;
      match_addr <= '0;
      vocab_rd   <= 1'b0;
      word_rd    <= 1'b0;
    end else begin
      state      <= state_nxt;
      wstart     <= wstart_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      found      <= found_nxt;
      match_id   <= match_id_nxt;
      match_addr <= match_addr_nxt;
      vocab_rd   <= vocab_rd_nxt;
      word_rd    <= word_rd_nxt;
    end
  end

endmodule

// File: tb/tb_vocab_matcher.sv
// Scoreboard bench for vocab_matcher with behavioural 1-cycle-latency SRAMs.
module tb_vocab_matcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, found, vocab_rd, word_rd;
  logic [7:0] match_id, match_addr, vocab_addr;
  logic [3:0] word_addr;
  logic [7:0] vocab_data = 8'h00;
  logic [7:0] word_data = 8'h00;

  logic [7:0] vmem [256];
  logic [7:0] wmem [16];

  int          checks = 0;
  int          errors = 0;
  logic [16:0] exp_q [$];
  logic [16:0] got, exp_r;
  int          cyc;
  bit          timed_out;

  int         rd_cnt = 0;
  logic [7:0] prev_addr = 8'h00;
  logic [7:0] max_addr = 8'h00;
  bit         seen_rd = 1'b0;
  bit         wrap_seen = 1'b0;

  always #5 clk = ~clk;

  vocab_matcher #(
    .DATA_WIDTH(8), .VOCAB_ADDR_WIDTH(8), .WORD_ADDR_WIDTH(4), .ID_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .match_id   (match_id),
    .match_addr (match_addr),
    .vocab_rd   (vocab_rd),
    .vocab_addr (vocab_addr),
    .vocab_data (vocab_data),
    .word_rd    (word_rd),
    .word_addr  (word_addr),
    .word_data  (word_data)
  );

  always @(posedge clk) begin
    if (vocab_rd) vocab_data <= vmem[vocab_addr];
    if (word_rd) word_data <= wmem[word_addr];
  end

  // Tracks vocabulary reads of the current search: count, highest address, any backward step.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || (start && !busy && !done)) begin
      rd_cnt = 0; seen_rd = 1'b0; wrap_seen = 1'b0; max_addr = 8'h00;
    end else if (vocab_rd) begin
      if (seen_rd && vocab_addr < prev_addr) wrap_seen = 1'b1;
      prev_addr = vocab_addr;
      seen_rd = 1'b1;
      rd_cnt++;
      if (vocab_addr > max_addr) max_addr = vocab_addr;
    end
  end

  // Reference search over the memory images: {found, id, start address}.
  function automatic logic [16:0] model();
    int s, k, p, e, idx;
    s = 0; idx = 0;
    if (wmem[0] == 8'h00) return '0;
    while (1'b1) begin
      if (vmem[s] == 8'h00) return '0;
      k = 0;
      while (k < 15 && s + k < 255 && vmem[s+k] == wmem[k] && wmem[k] != 8'h00) k++;
      p = s + k;
      if (vmem[p] == wmem[k] && wmem[k] == 8'h00) return {1'b1, 8'(idx), 8'(s)};
      if (p == 255) return '0;
      e = p;
      while (vmem[e] != 8'h00) begin
        if (e == 255) return '0;
        e++;
      end
      if (e == 255 || idx == 255) return '0;
      s = e + 1;
      idx++;
    end
    return '0;
  endfunction

  // '.' in the text stands for the zero terminator.
  task automatic load_vocab(input string s);
    for (int i = 0; i < 256; i++) vmem[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) vmem[i] = (s[i] == 8'h2e) ? 8'h00 : 8'(s[i]);
  endtask

  task automatic load_word(input string s);
    for (int i = 0; i < 16; i++) wmem[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) wmem[i] = (s[i] == 8'h2e) ? 8'h00 : 8'(s[i]);
  endtask

  task automatic launch();
    exp_q.push_back(model());
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    cyc = 1;
    timed_out = 1'b0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) timed_out = 1'b1;
    got = {found, match_id, match_addr};
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, found, match_id, match_addr, vocab_rd, vocab_addr, word_rd, word_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b found=%b id=%h addr=%h vrd=%b va=%h wrd=%b wa=%h, expected all 0",
               busy, done, found, match_id, match_addr, vocab_rd, vocab_addr, word_rd, word_addr);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_second_word();
    load_vocab("cat.dog.."); load_word("dog.");
    launch(); wait_done(200);
    exp_r = exp_q.pop_front(); checks++;
    if (timed_out || got !== exp_r) begin
      errors++; $display("FAIL second_word: got %h timeout=%0b, expected %h", got, timed_out, exp_r);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b, expected 0", busy); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: done=%b one cycle later, expected 0", done); end
  endtask

  task automatic test_first_word_latency();
    load_vocab("cat.dog.."); load_word("cat.");
    launch(); wait_done(200);
    exp_r = exp_q.pop_front(); checks++;
    if (timed_out || got !== exp_r) begin
      errors++; $display("FAIL first_word: got %h timeout=%0b, expected %h", got, timed_out, exp_r);
    end
    checks++;
    if (cyc != 9) begin errors++; $display("FAIL first_word_latency: got %0d cycles, expected 9", cyc); end
  endtask

  task automatic test_not_found();
    load_vocab("cat.dog.."); load_word("cow.");
    launch(); wait_done(200);
    exp_r = exp_q.pop_front(); checks++;
    if (timed_out || got !== exp_r) begin
      errors++; $display("FAIL not_found: got %h timeout=%0b, expected %h", got, timed_out, exp_r);
    end
    checks++;
    if (vocab_addr !== 8'd8 || max_addr !== 8'd8) begin
      errors++; $display("FAIL vocab_end_addr: vocab_addr=%0d max_read=%0d, expected 8 and 8", vocab_addr, max_addr);
    end
  endtask

  task automatic test_prefix_trap();
    load_vocab("ca.cat.."); load_word("cat.");
    launch(); wait_done(200);
    exp_r = exp_q.pop_front(); checks++;
    if (timed_out || got !== exp_r) begin
      errors++; $display("FAIL prefix_trap: got %h timeout=%0b, expected %h", got, timed_out, exp_r);
    end
  endtask

  task automatic test_empty_input();
    load_vocab("cat.dog.."); load_word(".");
    launch(); wait_done(50);
    exp_r = exp_q.pop_front(); checks++;
    if (timed_out || got !== exp_r) begin
      errors++; $display("FAIL empty_input: got %h timeout=%0b, expected %h", got, timed_out, exp_r);
    end
    checks++;
    if (cyc != 3 || rd_cnt != 1) begin
      errors++; $display("FAIL empty_timing: latency=%0d reads=%0d, expected 3 and 1", cyc, rd_cnt);
    end
  endtask

  task automatic test_vocab_full();
    for (int i = 0; i < 256; i++) vmem[i] = 8'h78;
    load_word("xx.");
    launch(); wait_done(2000);
    exp_r = exp_q.pop_front(); checks++;
    if (timed_out || got !== exp_r) begin
      errors++; $display("FAIL vocab_full: got %h timeout=%0b, expected %h", got, timed_out, exp_r);
    end
    checks++;
    if (wrap_seen || max_addr !== 8'hff || vocab_addr !== 8'hff) begin
      errors++; $display("FAIL no_wrap: wrap=%0b max_read=%h vocab_addr=%h, expected 0 ff ff", wrap_seen, max_addr, vocab_addr);
    end
  endtask

  task automatic test_start_in_done();
    bit busy_seen;
    load_vocab("ca.cat.."); load_word("ca.");
    launch(); wait_done(200);
    exp_r = exp_q.pop_front(); checks++;
    if (timed_out || got !== exp_r) begin
      errors++; $display("FAIL short_word: got %h timeout=%0b, expected %h", got, timed_out, exp_r);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0; busy_seen = busy;
    @(negedge clk); busy_seen = busy_seen | busy;
    checks++;
    if (busy_seen) begin errors++; $display("FAIL start_in_done: busy=1 after start in DONE, expected 0"); end
  endtask

  task automatic test_back_to_back();
    load_vocab("ca.cat.."); load_word("cat.");
    launch(); wait_done(200);
    exp_r = exp_q.pop_front(); checks++;
    if (timed_out || got !== exp_r) begin
      errors++; $display("FAIL b2b_first: got %h timeout=%0b, expected %h", got, timed_out, exp_r);
    end
    load_word("dog.");
    launch(); wait_done(200);
    exp_r = exp_q.pop_front(); checks++;
    if (timed_out || got !== exp_r) begin
      errors++; $display("FAIL b2b_second: got %h timeout=%0b, expected %h", got, timed_out, exp_r);
    end
  endtask

  task automatic test_reset_mid_search();
    for (int i = 0; i < 256; i++) vmem[i] = 8'h78;
    load_word("xx.");
    launch();
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || wrap_seen) begin
      errors++; $display("FAIL start_while_busy: busy=%b restart=%0b, expected 1 0", busy, wrap_seen);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, found, match_id, match_addr, vocab_rd, vocab_addr, word_rd, word_addr} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%b done=%b found=%b id=%h addr=%h vrd=%b va=%h wrd=%b wa=%h, expected all 0",
               busy, done, found, match_id, match_addr, vocab_rd, vocab_addr, word_rd, word_addr);
    end
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    load_vocab("cat.dog.."); load_word("dog.");
    launch(); wait_done(200);
    exp_r = exp_q.pop_front(); checks++;
    if (timed_out || got !== exp_r) begin
      errors++; $display("FAIL after_reset: got %h timeout=%0b, expected %h", got, timed_out, exp_r);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) vmem[i] = 8'h00;
    for (int i = 0; i < 16; i++) wmem[i] = 8'h00;
    test_reset();
    test_second_word();
    test_first_word_latency();
    test_not_found();
    test_prefix_trap();
    test_empty_input();
    test_vocab_full();
    test_start_in_done();
    test_back_to_back();
    test_reset_mid_search();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
